// File: rtl/button_repeat.sv
`default_nettype none
// ============================================================================
// Module   : button_repeat
// Purpose  : Synchronizes and debounces a raw button, then emits a press pulse
//            followed by optional periodic auto-repeat pulses while held.
// Revision : 1.0 - initial release
// ============================================================================
module button_repeat #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int HOLD_DELAY_CYCLES = 10,
  parameter int REPEAT_CYCLES     = 3,
  parameter bit REPEAT_EN         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic held,
  output logic pulse,
  output logic repeating
);

  localparam int c_db_w  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_t_max = (HOLD_DELAY_CYCLES > REPEAT_CYCLES) ? HOLD_DELAY_CYCLES : REPEAT_CYCLES;
  localparam int c_tm_w  = $clog2(c_t_max + 1);

  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_db_w-1:0] c_db_one  = c_db_w'(1);
  localparam logic [c_tm_w-1:0] c_hold    = c_tm_w'(HOLD_DELAY_CYCLES);
  localparam logic [c_tm_w-1:0] c_rep     = c_tm_w'(REPEAT_CYCLES);
  localparam logic [c_tm_w-1:0] c_tm_one  = c_tm_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic              r_s1;
  logic              r_s2;
  logic [c_db_w-1:0] r_db_cnt;
  logic [c_tm_w-1:0] r_timer;
  state_t            r_state;

  state_t            w_state_nxt;
  logic [c_tm_w-1:0] w_timer_nxt;
  logic [c_tm_w-1:0] w_timer_inc;
  logic              w_pulse_nxt;
  logic              w_rep_nxt;
  logic              w_toggle;
  logic              w_rise;
  logic              w_fall;

  // held flips on the same edge the count would reach DEBOUNCE_CYCLES
  assign w_toggle    = (r_s2 != held) && (r_db_cnt == c_db_last);
  assign w_rise      = w_toggle && !held;
  assign w_fall      = w_toggle && held;
  assign w_timer_inc = r_timer + c_tm_one;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      held     <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
      if (w_toggle) begin
        held     <= ~held;
        r_db_cnt <= '0;
      end else if (r_s2 != held) begin
        r_db_cnt <= r_db_cnt + c_db_one;
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      pulse     <= 1'b0;
      repeating <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      pulse     <= w_pulse_nxt;
      repeating <= w_rep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pulse_nxt = 1'b0;
    w_rep_nxt   = repeating;
    // a release wins over any coincident timer expiry
    if (w_fall) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_rep_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_rep_nxt = 1'b0;
          if (w_rise) begin
            w_pulse_nxt = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (REPEAT_EN == 1'b0) begin
            if (r_timer != c_hold) w_timer_nxt = w_timer_inc;
          end else if (w_timer_inc == c_hold) begin
            w_pulse_nxt = 1'b1;
            w_timer_nxt = '0;
            w_rep_nxt   = 1'b1;
            w_state_nxt = ST_REPEAT;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
        ST_REPEAT: begin
          if (w_timer_inc == c_rep) begin
            w_pulse_nxt = 1'b1;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
          w_rep_nxt   = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_repeat.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_repeat
// Purpose  : Directed self-checking bench for button_repeat (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_repeat;

  logic clk;
  logic rst_n;
  logic in;
  logic held;
  logic pulse;
  logic repeating;

  int n_cmp;
  int n_bad;

  button_repeat #(
    .DEBOUNCE_CYCLES  (4),
    .HOLD_DELAY_CYCLES(10),
    .REPEAT_CYCLES    (3),
    .REPEAT_EN        (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .held     (held),
    .pulse    (pulse),
    .repeating(repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [2:0] exp_v;
    rst_n = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      in = ~in;
      tick();
      exp_v = 3'b000;
      n_cmp++;
      if ({held, pulse, repeating} !== exp_v) begin
        n_bad++;
        $display("FAIL reset e%0d: got {held,pulse,rep}=%b want %b", e, {held, pulse, repeating}, exp_v);
      end
    end
    in    = 1'b0;
    rst_n = 1'b1;
    idle_cycles(4);
  endtask

  // High for 3 sampling edges: too short to be accepted.
  task automatic test_glitch();
    logic [2:0] exp_v;
    for (int e = 1; e <= 10; e++) begin
      in = (e <= 3);
      tick();
      exp_v = 3'b000;
      n_cmp++;
      if ({held, pulse, repeating} !== exp_v) begin
        n_bad++;
        $display("FAIL glitch e%0d: got {held,pulse,rep}=%b want %b", e, {held, pulse, repeating}, exp_v);
      end
    end
  endtask

  // High for exactly 4 sampling edges: accepted at edge 6, released at edge 10.
  task automatic test_min_press();
    logic [2:0] exp_v;
    for (int e = 1; e <= 12; e++) begin
      in = (e <= 4);
      tick();
      exp_v = {(e >= 6 && e < 10), (e == 6), 1'b0};
      n_cmp++;
      if ({held, pulse, repeating} !== exp_v) begin
        n_bad++;
        $display("FAIL min_press e%0d: got {held,pulse,rep}=%b want %b", e, {held, pulse, repeating}, exp_v);
      end
    end
    idle_cycles(3);
  endtask

  // Press: held/pulse rise at edge 6; the caller continues with auto-repeat.
  task automatic test_press();
    logic [2:0] exp_v;
    in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_v = {(e >= 6), (e == 6), 1'b0};
      n_cmp++;
      if ({held, pulse, repeating} !== exp_v) begin
        n_bad++;
        $display("FAIL press e%0d: got {held,pulse,rep}=%b want %b", e, {held, pulse, repeating}, exp_v);
      end
    end
  endtask

  // Press pulse at edge 6; repeats at 16, 19, 22, 25, 28.
  task automatic test_auto_repeat();
    logic [2:0] exp_v;
    logic       exp_p;
    for (int e = 8; e <= 28; e++) begin
      tick();
      exp_p = (e == 16) || (e == 19) || (e == 22) || (e == 25) || (e == 28);
      exp_v = {1'b1, exp_p, (e >= 16)};
      n_cmp++;
      if ({held, pulse, repeating} !== exp_v) begin
        n_bad++;
        $display("FAIL auto_repeat e%0d: got {held,pulse,rep}=%b want %b", e, {held, pulse, repeating}, exp_v);
      end
    end
  endtask

  // Release sampled at relative edge 1 (absolute 29): repeat timer still fires
  // at relative 3 while held is up; the expiry at relative 6 coincides with the
  // held fall and must be suppressed.
  task automatic test_release();
    logic [2:0] exp_v;
    in = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      tick();
      exp_v = {(r < 6), (r == 3), (r < 6)};
      n_cmp++;
      if ({held, pulse, repeating} !== exp_v) begin
        n_bad++;
        $display("FAIL release r%0d: got {held,pulse,rep}=%b want %b", r, {held, pulse, repeating}, exp_v);
      end
    end
  endtask

  // Reset on edge 19 (a repeat expiry) while held, then re-press after release.
  task automatic test_reset_mid();
    logic [2:0] exp_v;
    in = 1'b1;
    idle_cycles(18);
    exp_v = 3'b101;
    n_cmp++;
    if ({held, pulse, repeating} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_mid pre: got {held,pulse,rep}=%b want %b", {held, pulse, repeating}, exp_v);
    end
    rst_n = 1'b0;
    tick();
    exp_v = 3'b000;
    n_cmp++;
    if ({held, pulse, repeating} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_mid at_reset: got {held,pulse,rep}=%b want %b", {held, pulse, repeating}, exp_v);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_v = {(e >= 6), (e == 6), 1'b0};
      n_cmp++;
      if ({held, pulse, repeating} !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid e%0d: got {held,pulse,rep}=%b want %b", e, {held, pulse, repeating}, exp_v);
      end
    end
    in = 1'b0;
    idle_cycles(8);
    exp_v = 3'b000;
    n_cmp++;
    if ({held, pulse, repeating} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_mid final: got {held,pulse,rep}=%b want %b", {held, pulse, repeating}, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in    = 1'b0;
    #1;
    test_reset();
    test_glitch();
    test_min_press();
    test_press();
    test_auto_repeat();
    test_release();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
